scan_master: RTL

SCAN_MASTER -- requirements
Module: scan_master

---
 rtl/scan_pkg.sv | 26 ++
 rtl/edge_sync.sv | 28 ++
 rtl/scan_master.sv | 181 ++++++++++++++++++
 3 files changed

// File: rtl/scan_pkg.sv
// Shared types and sizing helpers for the scan-chain master.
package scan_pkg;

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        SHIFT    = 3'd1,
        UPDATE   = 3'd2,
        WAIT_RET = 3'd3,
        DONE     = 3'd4
    } state_t;

    localparam int unsigned NUM_IOS_DEF = 8;
    localparam int unsigned ADDR_W_DEF  = 8;
    localparam int unsigned FRAME_LEN   = ADDR_W_DEF + NUM_IOS_DEF;
    localparam int unsigned RET_CNT_W   = $clog2(FRAME_LEN + 2);

    function automatic int unsigned frame_len_f(input int unsigned addr_w, input int unsigned num_ios);
        return addr_w + num_ios;
    endfunction

    // Bits needed to hold the value max_val (never less than one).
    function automatic int unsigned cnt_w_f(input int unsigned max_val);
        return (max_val < 2) ? 1 : $clog2(max_val + 1);
    endfunction

endpackage

// File: rtl/edge_sync.sv
// Synchronizes the returned scan clock and flags its rising edges; tdo rides an equal-length pipe.
module edge_sync (
    input  logic clk,
    input  logic reset,
    input  logic rtck,
    input  logic tdo,
    output logic rise_c,
    output logic tdo_s
);

    logic [2:0] rtck_q;
    logic [1:0] tdo_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            rtck_q <= '0;
            tdo_q  <= '0;
        end else begin
            rtck_q <= {rtck_q[1:0], rtck};
            tdo_q  <= {tdo_q[0], tdo};
        end
    end

    // tdo_q[1] holds the data sampled alongside rtck_q[1].
    assign rise_c = rtck_q[1] & ~rtck_q[2];
    assign tdo_s  = tdo_q[1];

endmodule

// File: rtl/scan_master.sv
// Shifts {addr, i_pins} out on a TCK/TMS/TDI chain and captures the returned project pins.
module scan_master
    import scan_pkg::*;
#(
    parameter int unsigned NUM_IOS = 8,
    parameter int unsigned ADDR_W  = 8,
    parameter int unsigned DIV     = 2,
    parameter int unsigned TIMEOUT = 256
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               start,
    input  logic [ADDR_W-1:0]  addr,
    input  logic [NUM_IOS-1:0] i_pins,
    input  logic               rtck,
    input  logic               tdo,
    output logic               tck,
    output logic               tms,
    output logic               tdi,
    output logic               busy,
    output logic               done,
    output logic               err,
    output logic [NUM_IOS-1:0] o_pins
);

    localparam int unsigned FLEN  = frame_len_f(ADDR_W, NUM_IOS);
    localparam int unsigned RET_W = cnt_w_f(FLEN + 1);
    localparam int unsigned BIT_W = cnt_w_f(FLEN);
    localparam int unsigned DIV_W = cnt_w_f(DIV);
    localparam int unsigned TO_W  = cnt_w_f(TIMEOUT);

    state_t             state_q, state_d;
    logic [FLEN-1:0]    shreg_q, shreg_d;
    logic [NUM_IOS-1:0] cap_q, cap_d;
    logic [RET_W-1:0]   ret_q, ret_d;
    logic [TO_W-1:0]    to_q, to_d;
    logic [DIV_W-1:0]   div_q, div_d;
    logic [BIT_W-1:0]   bit_q, bit_d;
    logic               tck_d, tms_d, tdi_d, busy_d, done_d, err_d;
    logic [NUM_IOS-1:0] o_pins_d;
    logic               fin_c;
    logic               rise_c;
    logic               tdo_s;

    edge_sync u_edge_sync (
        .clk    (clk),
        .reset  (reset),
        .rtck   (rtck),
        .tdo    (tdo),
        .rise_c (rise_c),
        .tdo_s  (tdo_s)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            shreg_q <= '0;
            cap_q   <= '0;
            ret_q   <= '0;
            to_q    <= '0;
            div_q   <= '0;
            bit_q   <= '0;
            tck     <= 1'b0;
            tms     <= 1'b0;
            tdi     <= 1'b0;
            busy    <= 1'b0;
            done    <= 1'b0;
            err     <= 1'b0;
            o_pins  <= '0;
        end else begin
            state_q <= state_d;
            shreg_q <= shreg_d;
            cap_q   <= cap_d;
            ret_q   <= ret_d;
            to_q    <= to_d;
            div_q   <= div_d;
            bit_q   <= bit_d;
            tck     <= tck_d;
            tms     <= tms_d;
            tdi     <= tdi_d;
            busy    <= busy_d;
            done    <= done_d;
            err     <= err_d;
            o_pins  <= o_pins_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        shreg_d  = shreg_q;
        cap_d    = cap_q;
        ret_d    = ret_q;
        to_d     = to_q;
        div_d    = div_q;
        bit_d    = bit_q;
        tck_d    = tck;
        tms_d    = tms;
        tdi_d    = tdi;
        busy_d   = busy;
        done_d   = 1'b0;
        err_d    = err;
        o_pins_d = o_pins;
        fin_c    = 1'b0;

        // Count returned edges for the whole frame; only the data window lands in cap.
        if (rise_c && (state_q != IDLE) && (ret_q != RET_W'(FLEN + 1))) begin
            ret_d = ret_q + RET_W'(1);
            if ((ret_q >= RET_W'(ADDR_W)) && (ret_q < RET_W'(FLEN))) begin
                cap_d = (cap_q << 1) | NUM_IOS'(tdo_s);
            end
        end

        case (state_q)
            IDLE: begin
                if (start) begin
                    shreg_d = {addr, i_pins};
                    cap_d   = '0;
                    ret_d   = '0;
                    div_d   = '0;
                    bit_d   = '0;
                    err_d   = 1'b0;
                    busy_d  = 1'b1;
                    tck_d   = 1'b0;
                    tms_d   = 1'b1;
                    tdi_d   = addr[ADDR_W-1];
                    state_d = SHIFT;
                end
            end
            SHIFT, UPDATE: begin
                if (div_q == DIV_W'(DIV - 1)) begin
                    div_d = '0;
                    tck_d = ~tck;
                    // Everything below happens on the tck falling edge.
                    if (tck) begin
                        if (state_q == UPDATE) begin
                            to_d    = '0;
                            state_d = WAIT_RET;
                        end else begin
                            shreg_d = shreg_q << 1;
                            if (bit_q == BIT_W'(FLEN - 1)) begin
                                tms_d   = 1'b0;
                                tdi_d   = 1'b0;
                                state_d = UPDATE;
                            end else begin
                                bit_d = bit_q + BIT_W'(1);
                                tdi_d = shreg_d[FLEN-1];
                            end
                        end
                    end
                end else begin
                    div_d = div_q + DIV_W'(1);
                end
            end
            WAIT_RET: begin
                if (ret_q == RET_W'(FLEN + 1)) begin
                    fin_c = 1'b1;
                end else if (to_q == TO_W'(TIMEOUT - 1)) begin
                    err_d = 1'b1;
                    fin_c = 1'b1;
                end else begin
                    to_d = to_q + TO_W'(1);
                end
                if (fin_c) begin
                    done_d  = 1'b1;
                    busy_d  = 1'b0;
                    state_d = DONE;
                    if (!err_d) begin
                        o_pins_d = cap_q;
                    end
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

endmodule
